// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral system bridge:
// FSM state encoding, slot-index width helper and the default device map.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Default map: timer, UART, switches, LEDs in consecutive 16-byte windows.
  localparam logic [127:0] DEF_DEV_BASE = {32'h0000_7F30, 32'h0000_7F20,
                                           32'h0000_7F10, 32'h0000_7F00};
  localparam logic [127:0] DEF_DEV_MASK = {4{32'hFFFF_FFF0}};

  // Slot index width; never zero so a single-device bridge still has an index.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/bridge_if.sv
// CPU-side and device-side signal bundle of the system bridge.
// The slave modport is the bridge itself; master is the CPU/device environment.
interface bridge_if #(
  parameter int unsigned NUM_DEV = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
);

  logic                      pr_req;
  logic [ADDR_W-1:0]         pr_addr;
  logic                      pr_we;
  logic [DATA_W/8-1:0]       pr_be;
  logic [DATA_W-1:0]         pr_wd;
  logic                      pr_busy;
  logic                      pr_ack;
  logic                      pr_err;
  logic [DATA_W-1:0]         pr_rd;
  logic [NUM_DEV-1:0]        dev_sel;
  logic                      dev_we;
  logic [ADDR_W-1:0]         dev_addr;
  logic [DATA_W/8-1:0]       dev_be;
  logic [DATA_W-1:0]         dev_wd;
  logic [NUM_DEV*DATA_W-1:0] dev_rd;
  logic [NUM_DEV-1:0]        dev_ready;

  modport master (
    output pr_req, pr_addr, pr_we, pr_be, pr_wd, dev_rd, dev_ready,
    input  pr_busy, pr_ack, pr_err, pr_rd,
    input  dev_sel, dev_we, dev_addr, dev_be, dev_wd
  );

  modport slave (
    input  pr_req, pr_addr, pr_we, pr_be, pr_wd, dev_rd, dev_ready,
    output pr_busy, pr_ack, pr_err, pr_rd,
    output dev_sel, dev_we, dev_addr, dev_be, dev_wd
  );

endinterface

// File: rtl/bridge_addr_decode.sv
// Combinational priority decoder: address -> {hit, slot index}.
// When several windows match, the lowest slot index wins.
module bridge_addr_decode
  import bridge_pkg::*;
#(
  parameter int unsigned                 NUM_DEV  = 4,
  parameter int unsigned                 ADDR_W   = 32,
  parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_BASE = DEF_DEV_BASE,
  parameter logic [NUM_DEV*ADDR_W-1:0]   DEV_MASK = DEF_DEV_MASK,
  parameter int unsigned                 IDX_W    = idx_width(NUM_DEV)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [NUM_DEV-1:0] match_s;

  // Per-slot window compare.
  always_comb begin
    match_s = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      match_s[k] = ((addr & DEV_MASK[k*ADDR_W +: ADDR_W]) == DEV_BASE[k*ADDR_W +: ADDR_W]);
    end
  end

  // Scan from the highest slot down so the lowest matching slot is left in idx.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_DEV - 1; k >= 0; k--) begin
      idx = match_s[k] ? IDX_W'(k) : idx;
      hit = hit | match_s[k];
    end
  end

endmodule

// File: rtl/sys_bridge_ctrl.sv
// Registered CPU-to-peripheral bridge: decodes a request, strobes one device,
// waits for its ready (bounded by TIMEOUT) and returns data with a one-cycle ack.
module sys_bridge_ctrl
  import bridge_pkg::*;
#(
  parameter int unsigned               NUM_DEV  = 4,
  parameter int unsigned               ADDR_W   = 32,
  parameter int unsigned               DATA_W   = 32,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE = DEF_DEV_BASE,
  parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK = DEF_DEV_MASK,
  parameter int unsigned               TIMEOUT  = 16
) (
  input  logic     clk,
  input  logic     reset,
  bridge_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_DEV);
  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);

  state_t              state_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [IDX_W-1:0]    slot_r;
  logic                we_r;
  logic [ADDR_W-1:0]   dev_addr_r;
  logic [BE_W-1:0]     dev_be_r;
  logic [DATA_W-1:0]   dev_wd_r;
  logic [NUM_DEV-1:0]  dev_sel_r;
  logic                pr_ack_r;
  logic                pr_err_r;
  logic [DATA_W-1:0]   pr_rd_r;

  logic                hit_s;
  logic [IDX_W-1:0]    idx_s;
  logic [ADDR_W-1:0]   mask_sel_s;
  logic [NUM_DEV-1:0]  onehot_s;
  logic                sel_ready_s;
  logic [DATA_W-1:0]   sel_rd_s;

  bridge_addr_decode #(
    .NUM_DEV  (NUM_DEV),
    .ADDR_W   (ADDR_W),
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK),
    .IDX_W    (IDX_W)
  ) u_decode (
    .addr (bus.pr_addr),
    .hit  (hit_s),
    .idx  (idx_s)
  );

  // Window mask and strobe pattern of the slot being decoded in IDLE.
  always_comb begin
    mask_sel_s = '0;
    onehot_s   = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      mask_sel_s  = (idx_s == IDX_W'(k)) ? DEV_MASK[k*ADDR_W +: ADDR_W] : mask_sel_s;
      onehot_s[k] = (idx_s == IDX_W'(k));
    end
  end

  // Return path from the latched slot; other slots' ready and data are ignored.
  always_comb begin
    sel_ready_s = 1'b0;
    sel_rd_s    = '0;
    for (int k = 0; k < NUM_DEV; k++) begin
      sel_ready_s = (slot_r == IDX_W'(k)) ? bus.dev_ready[k] : sel_ready_s;
      sel_rd_s    = (slot_r == IDX_W'(k)) ? bus.dev_rd[k*DATA_W +: DATA_W] : sel_rd_s;
    end
  end

  // Bridge FSM with registered strobe, request latches and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      slot_r     <= '0;
      we_r       <= 1'b0;
      dev_addr_r <= '0;
      dev_be_r   <= '0;
      dev_wd_r   <= '0;
      dev_sel_r  <= '0;
      pr_ack_r   <= 1'b0;
      pr_err_r   <= 1'b0;
      pr_rd_r    <= '0;
    end else begin
      pr_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.pr_req) begin
            we_r       <= bus.pr_we;
            dev_addr_r <= bus.pr_addr & ~mask_sel_s;
            dev_be_r   <= bus.pr_be;
            dev_wd_r   <= bus.pr_wd;
            if (hit_s) begin
              slot_r    <= idx_s;
              cnt_r     <= '0;
              dev_sel_r <= onehot_s;
              state_r   <= ST_ACCESS;
            end else begin
              pr_err_r <= 1'b1;
              pr_rd_r  <= '0;
              pr_ack_r <= 1'b1;
              state_r  <= ST_RESP;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (sel_ready_s) begin
            // A write completes with zero read data.
            pr_rd_r   <= we_r ? '0 : sel_rd_s;
            pr_err_r  <= 1'b0;
            pr_ack_r  <= 1'b1;
            dev_sel_r <= '0;
            state_r   <= ST_RESP;
          end else if (cnt_r == CNT_LAST) begin
            pr_rd_r   <= '0;
            pr_err_r  <= 1'b1;
            pr_ack_r  <= 1'b1;
            dev_sel_r <= '0;
            state_r   <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          dev_sel_r <= '0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pr_busy  = (state_r != ST_IDLE);
  assign bus.pr_ack   = pr_ack_r;
  assign bus.pr_err   = pr_err_r;
  assign bus.pr_rd    = pr_rd_r;
  assign bus.dev_sel  = dev_sel_r;
  assign bus.dev_we   = we_r;
  assign bus.dev_addr = dev_addr_r;
  assign bus.dev_be   = dev_be_r;
  assign bus.dev_wd   = dev_wd_r;

endmodule

// File: tb/tb_sys_bridge_ctrl.sv
// Self-checking bench for sys_bridge_ctrl: directed scenarios plus randomized
// transactions against a transaction-level model of the bridge's latency rules.
module tb_sys_bridge_ctrl;

  localparam int NUM_DEV = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  // Slot 3 covers 0x7F00..0x7FFF and so overlaps every other slot.
  localparam logic [127:0] TB_BASE = {32'h0000_7F00, 32'h0000_7F20, 32'h0000_7F10, 32'h0000_7F00};
  localparam logic [127:0] TB_MASK = {32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bridge_if #(.NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sys_bridge_ctrl #(
    .NUM_DEV  (NUM_DEV),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .DEV_BASE (TB_BASE),
    .DEV_MASK (TB_MASK),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] m_base [4] = '{32'h7F00, 32'h7F10, 32'h7F20, 32'h7F00};
  logic [31:0] m_mask [4] = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FF00};
  logic [31:0] last_rd  = 32'h0;
  logic        last_err = 1'b0;

  function automatic int model_slot(input logic [31:0] a);
    for (int k = 0; k < 4; k++) begin
      if ((a & m_mask[k]) == m_base[k]) return k;
    end
    return -1;
  endfunction

  task automatic run_txn(input string name, input logic [31:0] addr, input logic we,
                         input logic [3:0] be, input logic [31:0] wd,
                         input int wait_n, input logic [31:0] rdata);
    int slot, exp_ack, exp_sel, sel_cnt, ack_c;
    logic exp_err;
    logic [31:0] exp_rd;
    logic [3:0] exp_oh, rdy;
    slot = model_slot(addr);
    if (slot < 0) begin
      exp_ack = 1; exp_sel = 0; exp_err = 1'b1; exp_rd = 32'h0; exp_oh = 4'b0000;
    end else begin
      exp_oh = 4'b0001 << slot;
      if (wait_n <= TIMEOUT - 1) begin
        exp_ack = wait_n + 2; exp_sel = wait_n + 1; exp_err = 1'b0;
        exp_rd = we ? 32'h0 : rdata;
      end else begin
        exp_ack = TIMEOUT + 1; exp_sel = TIMEOUT; exp_err = 1'b1; exp_rd = 32'h0;
      end
    end
    checks++;
    if (bus.pr_busy !== 1'b0) begin
      errors++; $display("FAIL %s idle_busy: got %b expected 0", name, bus.pr_busy);
    end
    bus.pr_req = 1'b1; bus.pr_addr = addr; bus.pr_we = we; bus.pr_be = be; bus.pr_wd = wd;
    for (int k = 0; k < NUM_DEV; k++) bus.dev_rd[k*DATA_W +: DATA_W] = (k == slot) ? rdata : $urandom;
    bus.dev_ready = 4'b0000;
    sel_cnt = 0; ack_c = 0;
    for (int c = 1; c <= TIMEOUT + 8 && ack_c == 0; c++) begin
      @(posedge clk); #1;
      if (bus.dev_sel !== 4'b0000) begin
        checks++;
        if (bus.dev_sel !== exp_oh) begin
          errors++; $display("FAIL %s dev_sel: got %b expected %b (cycle %0d)", name, bus.dev_sel, exp_oh, c);
        end else sel_cnt++;
        if (c == 1 && slot >= 0) begin
          checks++;
          if (bus.dev_addr !== (addr & ~m_mask[slot]) || bus.dev_we !== we ||
              bus.dev_be !== be || bus.dev_wd !== wd) begin
            errors++;
            $display("FAIL %s dev_latch: got addr=%h we=%b be=%b wd=%h expected addr=%h we=%b be=%b wd=%h",
                     name, bus.dev_addr, bus.dev_we, bus.dev_be, bus.dev_wd,
                     addr & ~m_mask[slot], we, be, wd);
          end
        end
      end
      if (bus.pr_ack === 1'b1) ack_c = c;
      else begin
        checks++;
        if (bus.pr_rd !== last_rd || bus.pr_err !== last_err) begin
          errors++; $display("FAIL %s hold: got rd=%h err=%b expected rd=%h err=%b (cycle %0d)",
                             name, bus.pr_rd, bus.pr_err, last_rd, last_err, c);
        end
      end
      rdy = 4'($urandom);
      if (slot >= 0) rdy[slot] = (c - 1 == wait_n);
      bus.dev_ready = rdy;
    end
    checks++;
    if (ack_c == 0) begin
      errors++; $display("FAIL %s ack_timeout: got no ack expected ack at cycle %0d", name, exp_ack);
    end else if (ack_c != exp_ack || bus.pr_err !== exp_err || bus.pr_rd !== exp_rd || sel_cnt != exp_sel) begin
      errors++;
      $display("FAIL %s response: got cyc=%0d err=%b rd=%h sel=%0d expected cyc=%0d err=%b rd=%h sel=%0d",
               name, ack_c, bus.pr_err, bus.pr_rd, sel_cnt, exp_ack, exp_err, exp_rd, exp_sel);
    end
    last_rd = exp_rd; last_err = exp_err;
    bus.pr_req = 1'b0; bus.dev_ready = 4'b0000;
    @(posedge clk); #1;
    checks++;
    if (bus.pr_ack !== 1'b0 || bus.pr_busy !== 1'b0) begin
      errors++; $display("FAIL %s ack_pulse: got ack=%b busy=%b expected 0 0", name, bus.pr_ack, bus.pr_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pr_req = 1'b0; bus.pr_addr = '0; bus.pr_we = 1'b0; bus.pr_be = '0; bus.pr_wd = '0;
    bus.dev_rd = '0; bus.dev_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.pr_busy !== 1'b0 || bus.pr_ack !== 1'b0 || bus.pr_err !== 1'b0 || bus.pr_rd !== 32'h0 ||
        bus.dev_sel !== 4'b0000 || bus.dev_addr !== 32'h0 || bus.dev_be !== 4'h0 || bus.dev_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b ack=%b err=%b rd=%h sel=%b addr=%h be=%b wd=%h expected all 0",
               bus.pr_busy, bus.pr_ack, bus.pr_err, bus.pr_rd, bus.dev_sel, bus.dev_addr, bus.dev_be, bus.dev_wd);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_txn("read_dev0",  32'h0000_7F04, 1'b0, 4'b1111, 32'h0,         0,  32'h1234_5678);
    run_txn("write_dev1", 32'h0000_7F18, 1'b1, 4'b0011, 32'hDEAD_BEEF, 3,  32'hCAFE_F00D);
    run_txn("unmapped",   32'h0000_1000, 1'b0, 4'b1111, 32'h0,         0,  32'h5555_AAAA);
    run_txn("timeout",    32'h0000_7F24, 1'b0, 4'b1111, 32'h0,         99, 32'h0BAD_0BAD);
  endtask

  task automatic test_boundaries();
    run_txn("ready_at_limit", 32'h0000_7F28, 1'b0, 4'b1111, 32'h0, TIMEOUT - 1, 32'hA5A5_5A5A);
    run_txn("overlap_low",    32'h0000_7F04, 1'b0, 4'b0001, 32'h0, 1, 32'h0000_0F0F);
    run_txn("slot3_only",     32'h0000_7F44, 1'b1, 4'b1100, 32'h1357_9BDF, 2, 32'h2468_ACE0);
  endtask

  task automatic test_random();
    logic [31:0] a;
    int w, r;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: a = 32'h0000_7F00 | 32'($urandom_range(0, 15));
        1: a = 32'h0000_7F10 | 32'($urandom_range(0, 15));
        2: a = 32'h0000_7F20 | 32'($urandom_range(0, 15));
        3: a = 32'h0000_7F30 + 32'($urandom_range(0, 207));
        default: a = $urandom;
      endcase
      r = $urandom_range(0, 9);
      w = (r == 0) ? TIMEOUT + 2 : (r == 1) ? TIMEOUT - 1 : $urandom_range(0, 5);
      run_txn("random", a, 1'($urandom), 4'($urandom), $urandom, w, $urandom);
    end
  endtask

  task automatic test_reset_mid_access();
    bus.pr_req = 1'b1; bus.pr_addr = 32'h0000_7F24; bus.pr_we = 1'b0; bus.dev_ready = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; bus.pr_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.dev_sel !== 4'b0000 || bus.pr_busy !== 1'b0 || bus.pr_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid_access: got sel=%b busy=%b ack=%b expected 0000 0 0",
                         bus.dev_sel, bus.pr_busy, bus.pr_ack);
    end
    reset = 1'b0;
    last_rd = 32'h0; last_err = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.pr_ack !== 1'b0 || bus.pr_busy !== 1'b0) begin
        errors++; $display("FAIL post_reset_quiet: got ack=%b busy=%b expected 0 0", bus.pr_ack, bus.pr_busy);
      end
    end
    run_txn("after_reset", 32'h0000_7F0C, 1'b0, 4'b1111, 32'h0, 2, 32'h0F1E_2D3C);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_boundaries();
    test_random();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sys_bridge_ctrl.md
# sys_bridge_ctrl

Parametrised, registered system bridge between the CPU data port and NUM_DEV memory-mapped peripherals (timer, UART, switches, LEDs). It decodes each CPU request against per-device base/mask windows, drives a one-hot device strobe, and waits for the device's ready handshake. It returns read data with a one-cycle acknowledge, and flags unmapped addresses and device timeouts as bus errors. It sits between the MEM stage and the peripheral devices and replaces the purely combinational bridge.

## Interface
- NUM_DEV, 4, number of device slots (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- DEV_BASE, {32'h7F30,32'h7F20,32'h7F10,32'h7F00}, packed NUM_DEV×ADDR_W base addresses; slot k at bits [k*ADDR_W +: ADDR_W]
- DEV_MASK, {4{32'hFFFF_FFF0}}, packed NUM_DEV×ADDR_W window masks
- TIMEOUT, 16, maximum ACCESS cycles before a bus error (≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- pr_req  in  1  CPU request; sampled only in IDLE
- pr_addr  in  ADDR_W  request address
- pr_we  in  1  1 = write, 0 = read
- pr_be  in  DATA_W/8  byte enables
- pr_wd  in  DATA_W  write data
- pr_busy  out  1  bridge not IDLE; CPU stalls
- pr_ack  out  1  one-cycle completion pulse
- pr_err  out  1  valid with pr_ack: unmapped or timeout
- pr_rd  out  DATA_W  read data, valid with pr_ack
- dev_sel  out  NUM_DEV  one-hot device strobe
- dev_we  out  1  write qualifier (meaningful only with dev_sel)
- dev_addr  out  ADDR_W  offset in window: latched addr & ~mask
- dev_be  out  DATA_W/8  latched byte enables
- dev_wd  out  DATA_W  latched write data
- dev_rd  in  NUM_DEV×DATA_W  packed device read data
- dev_ready  in  NUM_DEV  per-device completion

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE with pr_req=1: latch addr/we/be/wd and decode. A device hits when (addr & DEV_MASK[k]) == DEV_BASE[k]; on overlap, the lowest index wins.
  - On a hit: latch the slot index, clear the timeout counter, go to ACCESS.
  - On a miss: set err, clear rd, go to RESP.
- ACCESS: dev_sel[slot]=1 and dev_we=latched we.
  - If dev_ready[slot]=1: capture dev_rd[slot] into rd (capture 0 if the access is a write), err=0, go to RESP.
  - Else if the counter equals TIMEOUT-1: err=1, rd=0, go to RESP.
  - Else: increment the counter.
  - dev_ready on unselected slots is ignored.
- RESP: pr_ack=1 for one cycle, then go to IDLE.
- pr_rd and pr_err hold their value until the next RESP.
- pr_req outside IDLE is ignored; the CPU must hold the request until it sees pr_ack.
- pr_busy = (state != IDLE).
- Reset values: state IDLE, counter 0, dev_sel 0, pr_ack 0, pr_err 0, pr_rd 0, dev_addr/dev_be/dev_wd 0, pr_busy 0.
- Reset mid-ACCESS: the strobe drops at the same edge and no ack is produced.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from pr_* to dev_*.
- Mapped access, request in cycle 0: dev_sel is high in cycle 1.
  - If dev_ready is high in cycle 1: pr_ack in cycle 2. Minimum latency is 2.
  - Each additional wait cycle adds 1.
- Unmapped access: pr_ack with pr_err in cycle 1.
- Timeout: dev_sel high for exactly TIMEOUT cycles, then pr_ack with pr_err.
- dev_ready in the same cycle the counter hits TIMEOUT-1: ready wins and there is no error.
- Back-to-back requests: a new request is accepted in the cycle after RESP. Throughput is at most 1 access per 3 cycles.

## Structure
- Package bridge_pkg: state enum (IDLE/ACCESS/RESP), index width function clog2(NUM_DEV), default base/mask constants.
- Sub-module bridge_addr_decode: combinational address to {hit, slot index} priority decoder, parametrised by NUM_DEV/ADDR_W/DEV_BASE/DEV_MASK.

## Test plan
- Read 0x7F04, device 0 ready in first ACCESS cycle, dev_rd[0]=0x1234_5678 -> dev_sel=0001 and dev_addr=0x4 in cycle 1; pr_ack with pr_rd=0x1234_5678 and pr_err=0 in cycle 2.
- Write 0x7F18, pr_wd=0xDEAD_BEEF, pr_be=4'b0011, device 1 ready after 3 wait cycles -> dev_we=1, dev_wd/dev_be latched, dev_sel=0010 for 4 cycles; pr_ack in cycle 5 with pr_rd=0.
- Read 0x0000_1000 (unmapped) -> no dev_sel; pr_ack with pr_err=1 and pr_rd=0 in cycle 1.
- Device 2 never ready, TIMEOUT=16 -> dev_sel=0100 for 16 cycles, then pr_ack with pr_err=1.
- Boundary cases:
  - dev_ready at the counter limit -> no error.
  - Overlapping windows (slots 0 and 3 both match) -> slot 0 selected.
  - reset asserted during ACCESS -> next cycle dev_sel=0, pr_busy=0, and no pr_ack.
